// File: rtl/ecc_uart_pkg.sv
// Shared definitions for the ECC UART command receiver and reporter.
package ecc_uart_pkg;

    localparam logic [7:0] OP_FAULT  = 8'h46;
    localparam logic [7:0] OP_DOUBLE = 8'h44;
    localparam logic [7:0] OP_REPORT = 8'h52;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } rx_state_e;

    typedef enum logic {
        P_OP,
        P_ARG
    } parse_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 deserialiser: input synchroniser, mid-bit sampling FSM, framed byte output.
module uart_rx_core
    import ecc_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1_q, sync2_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= uart_rxd;
            sync2_q <= sync1_q;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // IDLE is only ever entered with the line high, so a low level here is a falling edge.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!sync2_q) state_d = START;
            end
            START: begin
                if (baud_q == HALF_M1) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_q == FULL_M1) begin
                    baud_d  = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (baud_q == FULL_M1) begin
                    baud_d = '0;
                    if (sync2_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK_WAIT;
                    end
                end
            end
            BREAK_WAIT: begin
                baud_d = '0;
                if (sync2_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;

endmodule

// File: rtl/ecc_uart_cmd_rx.sv
// Host command receiver: parses F/D/R commands from the UART into fault-injection controls.
module ecc_uart_cmd_rx
    import ecc_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int MAX_POS      = 21,
    parameter int TIMEOUT_CLKS = 10 * 868 * 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       inject,
    output logic [4:0] fault_pos,
    output logic       double_error,
    output logic       report_req,
    output logic       frame_err,
    output logic       cmd_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CLKS);
    localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0] MAX_POS_B = 8'(MAX_POS);

    parse_state_e     pstate_q, pstate_d;
    logic             op_dbl_q, op_dbl_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [4:0]       pos_q, pos_d;
    logic             dbl_q, dbl_d;
    logic             inj_q, inj_d;
    logic             rep_q, rep_d;
    logic             err_q, err_d;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .reset    (reset),
        .uart_rxd (uart_rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pstate_q <= P_OP;
            op_dbl_q <= 1'b0;
            tmo_q    <= '0;
            pos_q    <= '0;
            dbl_q    <= 1'b0;
            inj_q    <= 1'b0;
            rep_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            pstate_q <= pstate_d;
            op_dbl_q <= op_dbl_d;
            tmo_q    <= tmo_d;
            pos_q    <= pos_d;
            dbl_q    <= dbl_d;
            inj_q    <= inj_d;
            rep_q    <= rep_d;
            err_q    <= err_d;
        end
    end

    // A byte arriving on the expiry cycle takes priority over the timeout.
    always_comb begin
        pstate_d = pstate_q;
        op_dbl_d = op_dbl_q;
        tmo_d    = tmo_q;
        pos_d    = pos_q;
        dbl_d    = dbl_q;
        inj_d    = 1'b0;
        rep_d    = 1'b0;
        err_d    = 1'b0;
        case (pstate_q)
            P_OP: begin
                tmo_d = TMO_RELOAD;
                if (rx_valid) begin
                    case (rx_data)
                        OP_FAULT: begin
                            op_dbl_d = 1'b0;
                            pstate_d = P_ARG;
                        end
                        OP_DOUBLE: begin
                            op_dbl_d = 1'b1;
                            pstate_d = P_ARG;
                        end
                        OP_REPORT: rep_d = 1'b1;
                        default:   err_d = 1'b1;
                    endcase
                end
            end
            P_ARG: begin
                tmo_d = tmo_q - 1'b1;
                if (rx_valid) begin
                    pstate_d = P_OP;
                    if (rx_data <= MAX_POS_B) begin
                        pos_d = rx_data[4:0];
                        dbl_d = op_dbl_q;
                        inj_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (frame_err) begin
                    pstate_d = P_OP;
                end else if (tmo_q == '0) begin
                    err_d    = 1'b1;
                    pstate_d = P_OP;
                end
            end
            default: pstate_d = P_OP;
        endcase
    end

    assign inject       = inj_q;
    assign fault_pos    = pos_q;
    assign double_error = dbl_q;
    assign report_req   = rep_q;
    assign cmd_err      = err_q;

endmodule

// File: doc/ecc_uart_cmd_rx.md
# ecc_uart_cmd_rx

UART command receiver for the 2D-ECC SECDED IP core; the inbound counterpart of the UART reporter's transmit line. It deserialises 8N1 bytes from a host, parses a small command set, and drives the fault-injection controls (`inject`, `fault_pos`, `double_error`) and a report request into the top-level ECC wrapper. This lets a bench PC inject faults and trigger statistics reports over the same serial link that carries the reports back.

## Interface

Parameters
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200 baud); must be ≥ 4.
- `MAX_POS`, default 21: highest legal fault position; 16 data bits plus row/column parity.
- `TIMEOUT_CLKS`, default 10 × 868 × 4: maximum idle time allowed between an opcode byte and its argument byte.

Ports
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `uart_rxd` in 1: asynchronous serial input; idles high.
- `rx_data` out 8: last correctly framed byte, held until the next one.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `inject` out 1: one-cycle fault-injection strobe.
- `fault_pos` out 5: fault bit position; held between commands.
- `double_error` out 1: 1 = the injector flips `fault_pos` and its neighbour; held.
- `report_req` out 1: one-cycle pulse that starts a UART report.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `cmd_err` out 1: one-cycle pulse on unknown opcode, out-of-range argument, or argument timeout.

## Operation

- **Input synchroniser:** `uart_rxd` passes through a 2-FF synchroniser (reset value 1). All logic uses the synchronised signal.
- **Receiver FSM**
  - IDLE: wait for a synchronised falling edge, then go to START.
  - START: count `CLKS_PER_BIT/2` (integer division) and resample. Low goes to DATA; high is a false start and returns to IDLE with no output.
  - DATA: take 8 samples, `CLKS_PER_BIT` apart, LSB first.
  - STOP: sample one bit period later.
    - High: update `rx_data` and pulse `rx_valid`, then go to IDLE.
    - Low: pulse `frame_err`, discard the byte, and go to BREAK_WAIT.
  - BREAK_WAIT: wait until the line is high, then go to IDLE.
- **Parser FSM** (P_OP, P_ARG), advanced only by `rx_valid`.
  - P_OP:
    - 0x46 ('F'): latch op = single, go to P_ARG.
    - 0x44 ('D'): latch op = double, go to P_ARG.
    - 0x52 ('R'): pulse `report_req` and stay in P_OP.
    - Any other byte: pulse `cmd_err`.
  - P_ARG, on a byte:
    - Byte ≤ `MAX_POS`: load `fault_pos` = byte[4:0], set `double_error` = (op == double), pulse `inject`.
    - Otherwise: pulse `cmd_err` and leave the outputs unchanged.
    - In both cases, return to P_OP.
  - P_ARG timeout counter: reloads on entry and counts down every cycle. On expiry it pulses `cmd_err` and returns to P_OP.
  - A `frame_err` while in P_ARG also returns to P_OP, without `cmd_err`.
- **Reset values:** every output is 0, except that `rx_data` is 0x00. Both FSMs go to IDLE/P_OP and all counters clear. A reset arriving mid-byte or mid-command discards the partial data; no pulses follow.

## Timing

- Data bit k is sampled at the start edge + `CLKS_PER_BIT/2` + (k+1)·`CLKS_PER_BIT` cycles, plus 2 cycles of synchroniser delay.
- `rx_valid` and `frame_err` assert the cycle after the stop-bit sample.
- `inject`, `report_req` and `cmd_err` assert the cycle after `rx_valid`.
- `fault_pos` and `double_error` update in the same cycle that `inject` asserts, and are stable while it is high.
- All pulses are exactly 1 cycle wide. At most one parser pulse occurs per received byte.
- A new start bit is accepted in the cycle after STOP returns to IDLE, so back-to-back bytes need no extra idle time.
- `rx_valid` and a timeout expiring in the same cycle: the byte wins and no timeout `cmd_err` is issued.

## Structure

- Package `ecc_uart_pkg` holds:
  - opcode constants `OP_FAULT` = 8'h46, `OP_DOUBLE` = 8'h44, `OP_REPORT` = 8'h52;
  - the receiver state enum (IDLE, START, DATA, STOP, BREAK_WAIT);
  - the parser state enum (P_OP, P_ARG).
  The UART reporter shares this package.
- Sub-module `uart_rx_core` contains the synchroniser, the receiver FSM, and the bit and baud counters; its outputs are `rx_data`, `rx_valid` and `frame_err`.
- The parser, timeout counter and output registers live in `ecc_uart_cmd_rx`.

## Test plan

All scenarios use `CLKS_PER_BIT` = 16 and `TIMEOUT_CLKS` = 1000.

- **Single fault:** send 0x46 then 0x05. Expect one `inject` pulse, `fault_pos` = 5, `double_error` = 0, and no `cmd_err`.
- **Double fault:** send 0x44 then 0x0A. Expect `inject`, `fault_pos` = 10, `double_error` = 1. Then send 0x52: expect one `report_req` pulse, with `fault_pos` and `double_error` unchanged.
- **Glitch rejection:** drive `uart_rxd` low for 5 cycles, then high. Expect no `rx_valid`, no `frame_err`, and the FSM back in IDLE. A following 0x52 must be received normally.
- **Framing error:** send 0x46, then a byte 0x05 whose stop bit is low. Expect `frame_err`, no `inject`, and the parser in P_OP. A subsequent lone 0x05 then gives `cmd_err` (it is parsed as an opcode).
- **Range and timeout:**
  - Send 0x46 then 0x1F (with `MAX_POS` = 21): expect `cmd_err`, no `inject`, and `fault_pos` unchanged.
  - Send 0x46, then nothing for 1000 cycles: expect `cmd_err` exactly once, with the pulse at expiry.
- **Reset and back-to-back:**
  - Assert `reset` during data bit 3 of 0x52: expect no pulses and all outputs 0.
  - Send 0x46, 0x03 and 0x52 with zero idle gap: expect `inject` (`fault_pos` = 3) followed by `report_req`.
